// File: rtl/mips_dbg_ctrl.sv
// Run-control and debug-access controller for the multicycle MIPS core: run/halt/step-N, PC breakpoints,
// serialised register/memory debug reads. Define MIPS_DBG_PERF_EN to build CycleCount/InstrCount.
module mips_dbg_ctrl #(
    parameter int NUM_BP = 2,
    parameter int MEM_AW = 6,
    parameter int STEP_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        CmdOp,
    input  logic [1:0]        CmdIdx,
    input  logic [31:0]       CmdArg,
    output logic              RespValid,
    output logic [31:0]       RespData,
    output logic              CpuEn,
    input  logic [31:0]       PC,
    input  logic              InstrDone,
    output logic [4:0]        DispReadReg,
    output logic [MEM_AW-1:0] DispReadMem,
    input  logic [31:0]       DispRegData,
    input  logic [31:0]       DispMemData,
    output logic              Halted,
    output logic              BpHit,
    output logic [1:0]        BpIdx,
    output logic [31:0]       CycleCount,
    output logic [31:0]       InstrCount
);
    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_READ} state_t;

    localparam logic [2:0] OP_RUN      = 3'd1;
    localparam logic [2:0] OP_HALT     = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_SET_BP   = 3'd4;
    localparam logic [2:0] OP_CLR_BP   = 3'd5;
    localparam logic [2:0] OP_READ_REG = 3'd6;
    localparam logic [2:0] OP_READ_MEM = 3'd7;

    state_t              state;
    state_t              next_state;
    logic [31:0]         bp_addr [NUM_BP];
    logic [NUM_BP-1:0]   bp_valid;
    logic                skip;
    logic                read_mem;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_target;
    logic [STEP_W-1:0]   step_arg;
    logic                accept;
    logic                instr_ev;
    logic                bp_match;
    logic [1:0]          bp_match_idx;
    logic                bp_event;
    logic                step_done;

    // Handshake: a command transfers on any rising edge where CmdValid and CmdReady are both high;
    // CmdReady drops only while a debug read is in flight.
    assign accept   = CmdValid & CmdReady;
    assign instr_ev = CpuEn & InstrDone;
    assign step_arg = CmdArg[STEP_W-1:0];

    // Descending scan so the lowest matching comparator wins.
    always_comb begin
        bp_match     = 1'b0;
        bp_match_idx = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid[i] && (bp_addr[i] == PC)) begin
                bp_match     = 1'b1;
                bp_match_idx = 2'(i);
            end
        end
    end

    assign bp_event  = instr_ev & ~skip & bp_match;
    assign step_done = (state == S_STEP) & InstrDone & ((step_cnt + STEP_W'(1)) == step_target);

    always_comb begin
        next_state = state;
        case (state)
            S_HALT: begin
                if (accept) begin
                    case (CmdOp)
                        OP_RUN:                   next_state = S_RUN;
                        OP_STEP:                  next_state = S_STEP;
                        OP_READ_REG, OP_READ_MEM: next_state = S_READ;
                        default:                  next_state = S_HALT;
                    endcase
                end
            end
            S_RUN, S_STEP: begin
                if (bp_event || step_done || (accept && (CmdOp == OP_HALT)))
                    next_state = S_HALT;
            end
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_HALT;
            CpuEn       <= 1'b0;
            Halted      <= 1'b1;
            CmdReady    <= 1'b1;
            RespValid   <= 1'b0;
            RespData    <= '0;
            BpHit       <= 1'b0;
            BpIdx       <= 2'd0;
            bp_valid    <= '0;
            skip        <= 1'b0;
            read_mem    <= 1'b0;
            step_cnt    <= '0;
            step_target <= STEP_W'(1);
            DispReadReg <= '0;
            DispReadMem <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
        end else begin
            state     <= next_state;
            CpuEn     <= (next_state == S_RUN) || (next_state == S_STEP);
            Halted    <= (next_state == S_HALT);
            CmdReady  <= (next_state != S_READ);
            RespValid <= 1'b0;

            // Comparator writes take effect next cycle; indices beyond NUM_BP match no slot.
            if (accept && ((CmdOp == OP_SET_BP) || (CmdOp == OP_CLR_BP))) begin
                for (int i = 0; i < NUM_BP; i++) begin
                    if (CmdIdx == 2'(i)) begin
                        bp_valid[i] <= (CmdOp == OP_SET_BP);
                        if (CmdOp == OP_SET_BP) bp_addr[i] <= CmdArg;
                    end
                end
            end

            if (accept && (state == S_HALT) && ((CmdOp == OP_RUN) || (CmdOp == OP_STEP))) begin
                skip        <= 1'b1;
                BpHit       <= 1'b0;
                BpIdx       <= 2'd0;
                step_cnt    <= '0;
                step_target <= (step_arg == '0) ? STEP_W'(1) : step_arg;
            end else if (instr_ev) begin
                skip <= 1'b0;
                if (state == S_STEP) step_cnt <= step_cnt + STEP_W'(1);
            end

            if (bp_event) begin
                BpHit <= 1'b1;
                BpIdx <= bp_match_idx;
            end

            if (accept && (state == S_HALT) && (CmdOp == OP_READ_REG)) begin
                DispReadReg <= CmdArg[4:0];
                read_mem    <= 1'b0;
            end
            if (accept && (state == S_HALT) && (CmdOp == OP_READ_MEM)) begin
                DispReadMem <= CmdArg[MEM_AW-1:0];
                read_mem    <= 1'b1;
            end

            if (state == S_READ) begin
                RespValid <= 1'b1;
                RespData  <= read_mem ? DispMemData : DispRegData;
            end
        end
    end

`ifdef MIPS_DBG_PERF_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            CycleCount <= '0;
            InstrCount <= '0;
        end else begin
            if (CpuEn)    CycleCount <= CycleCount + 32'd1;
            if (instr_ev) InstrCount <= InstrCount + 32'd1;
        end
    end
`else
    assign CycleCount = '0;
    assign InstrCount = '0;
`endif

endmodule
